// File: rtl/glb_fm_rd_port_pkg.sv
// -----------------------------------------------------------------------------
// glb_fm_rd_port_pkg
// Shared constants, types and helpers for the GLB feature-map read port.
// No ports (package).
// -----------------------------------------------------------------------------
package glb_fm_rd_port_pkg;

   localparam int unsigned POOL_CORE      = 6;
   localparam int unsigned POOL_COMP_CORE = 64;
   localparam int unsigned IDX_WIDTH      = 10;
   localparam int unsigned ACT_WIDTH      = 8;
   localparam int unsigned FIFO_DEPTH     = 2;

   localparam int unsigned FM_W        = ACT_WIDTH * POOL_COMP_CORE;
   localparam int unsigned CORE_IDX_W  = $clog2(POOL_CORE);
   // SRAM returns data this many cycles after RdEn; the single tag stage matches it.
   localparam int unsigned SRAM_RD_LAT = 1;
   localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH + 1);

   // Tracks which channel owns the read currently in the SRAM pipeline.
   typedef struct packed {
      logic                  vld;
      logic [CORE_IDX_W-1:0] idx;
   } rd_tag_t;

   // FIFO pointer increment with wrap at FIFO_DEPTH (depth need not be a power of 2).
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

endpackage

// File: rtl/glb_fm_rd_port_if.sv
// -----------------------------------------------------------------------------
// glb_fm_rd_port_if
// Pooling memory-interface <-> GLB read channels, all POOL_CORE lanes flattened.
//   MIFGLB_AddrVld/Addr : per-channel request (master drives)
//   GLBMIF_AddrRdy      : per-channel request accept (slave drives)
//   GLBMIF_Fm/FmVld     : per-channel returned word (slave drives)
//   MIFGLB_FmRdy        : per-channel return ready (master drives)
// -----------------------------------------------------------------------------
interface glb_fm_rd_port_if;
   import glb_fm_rd_port_pkg::*;

   logic [POOL_CORE-1:0]           MIFGLB_AddrVld;
   logic [IDX_WIDTH*POOL_CORE-1:0] MIFGLB_Addr;
   logic [POOL_CORE-1:0]           GLBMIF_AddrRdy;
   logic [FM_W*POOL_CORE-1:0]      GLBMIF_Fm;
   logic [POOL_CORE-1:0]           GLBMIF_FmVld;
   logic [POOL_CORE-1:0]           MIFGLB_FmRdy;

   modport master (
      output MIFGLB_AddrVld, MIFGLB_Addr, MIFGLB_FmRdy,
      input  GLBMIF_AddrRdy, GLBMIF_Fm, GLBMIF_FmVld
   );

   modport slave (
      input  MIFGLB_AddrVld, MIFGLB_Addr, MIFGLB_FmRdy,
      output GLBMIF_AddrRdy, GLBMIF_Fm, GLBMIF_FmVld
   );

endinterface

// File: rtl/glb_rd_rr_arb.sv
// -----------------------------------------------------------------------------
// glb_rd_rr_arb
// Round-robin arbiter over POOL_CORE requesters, at most one grant per cycle.
//   clk, rst_n   : clock, async active-low reset (rr pointer -> 0)
//   eligible_i   : per-channel request, already credit-qualified
//   grant_o      : one-hot grant (or zero)
//   idx_o/vld_o  : encoded index of the grant and its valid
// -----------------------------------------------------------------------------
module glb_rd_rr_arb
   import glb_fm_rd_port_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [POOL_CORE-1:0]  eligible_i,
   output logic [POOL_CORE-1:0]  grant_o,
   output logic [CORE_IDX_W-1:0] idx_o,
   output logic                  vld_o
);

   logic [CORE_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [CORE_IDX_W:0]   sum;
   logic [CORE_IDX_W-1:0] cand;

   // Scan from rr_ptr upward with wrap; first eligible channel wins.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      vld_o   = 1'b0;
      sum     = '0;
      cand    = '0;
      for (int unsigned off = 0; off < POOL_CORE; off++) begin
         sum = {1'b0, rr_ptr_q} + (CORE_IDX_W + 1)'(off);
         if (sum >= (CORE_IDX_W + 1)'(POOL_CORE)) begin
            sum = sum - (CORE_IDX_W + 1)'(POOL_CORE);
         end
         cand = sum[CORE_IDX_W-1:0];
         if (!vld_o && eligible_i[cand]) begin
            vld_o         = 1'b1;
            idx_o         = cand;
            grant_o[cand] = 1'b1;
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (vld_o) begin
         rr_ptr_d = (idx_o == CORE_IDX_W'(POOL_CORE - 1)) ? '0 : idx_o + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

endmodule

// File: rtl/glb_fm_rd_port.sv
// -----------------------------------------------------------------------------
// glb_fm_rd_port
// GLB-side responder: arbitrates per-channel read requests onto one SRAM read
// port and returns each word on the requesting channel through a small FIFO.
//   clk, rst_n      : clock, async active-low reset
//   mif (slave)     : per-channel request/return handshakes
//   GLBSRAM_RdEn    : SRAM read enable (same cycle as the grant)
//   GLBSRAM_RdAddr  : SRAM read address (holds last value when idle)
//   SRAMGLB_RdDat   : SRAM read data, valid one cycle after RdEn
// -----------------------------------------------------------------------------
module glb_fm_rd_port
   import glb_fm_rd_port_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   glb_fm_rd_port_if.slave      mif,
   output logic                 GLBSRAM_RdEn,
   output logic [IDX_WIDTH-1:0] GLBSRAM_RdAddr,
   input  logic [FM_W-1:0]      SRAMGLB_RdDat
);

   logic [POOL_CORE-1:0]  eligible, grant, pop;
   logic [CORE_IDX_W-1:0] gnt_idx;
   logic                  gnt_vld;
   logic [IDX_WIDTH-1:0]  gnt_addr, rd_addr_q;
   rd_tag_t               tag_q;

   glb_rd_rr_arb u_arb (
      .clk        (clk),
      .rst_n      (rst_n),
      .eligible_i (eligible),
      .grant_o    (grant),
      .idx_o      (gnt_idx),
      .vld_o      (gnt_vld)
   );

   // Address of the granted channel; falls back to the last issued address.
   always_comb begin
      gnt_addr = rd_addr_q;
      for (int i = 0; i < POOL_CORE; i++) begin
         if (grant[i]) begin
            gnt_addr = mif.MIFGLB_Addr[IDX_WIDTH*i +: IDX_WIDTH];
         end
      end
   end

   assign GLBSRAM_RdEn       = gnt_vld;
   assign GLBSRAM_RdAddr     = gnt_addr;
   assign mif.GLBMIF_AddrRdy = grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_q     <= '0;
         rd_addr_q <= '0;
      end else begin
         tag_q.vld <= gnt_vld;
         if (gnt_vld) begin
            tag_q.idx <= gnt_idx;
         end
         rd_addr_q <= gnt_addr;
      end
   end

   for (genvar i = 0; i < POOL_CORE; i++) begin : g_ch
      logic [FM_W-1:0]  mem_q [FIFO_DEPTH];
      logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
      logic [CNT_W-1:0] cnt_q, rsv_q;
      logic             push, not_empty;

      assign push      = tag_q.vld && (tag_q.idx == CORE_IDX_W'(i));
      assign not_empty = (cnt_q != '0);
      assign pop[i]    = not_empty && mif.MIFGLB_FmRdy[i];

      // rsv_q counts stored words plus the read in flight, so a grant can never
      // overflow the FIFO; a same-cycle pop frees a slot for a full channel.
      // Gating with rst_n keeps AddrRdy/RdEn low while reset is held.
      assign eligible[i] = rst_n && mif.MIFGLB_AddrVld[i] &&
                           ((rsv_q < CNT_W'(FIFO_DEPTH)) || pop[i]);

      assign mif.GLBMIF_FmVld[i]          = not_empty;
      assign mif.GLBMIF_Fm[FM_W*i +: FM_W] = not_empty ? mem_q[rd_ptr_q] : '0;

      always_ff @(posedge clk) begin
         if (push) begin
            mem_q[wr_ptr_q] <= SRAMGLB_RdDat;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rsv_q    <= '0;
         end else begin
            if (push) begin
               wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop[i]) begin
               rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop[i]);
            rsv_q <= rsv_q + CNT_W'(grant[i]) - CNT_W'(pop[i]);
         end
      end
   end

endmodule

// File: tb/tb_glb_fm_rd_port.sv
module tb_glb_fm_rd_port;
   import glb_fm_rd_port_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 GLBSRAM_RdEn;
   logic [IDX_WIDTH-1:0] GLBSRAM_RdAddr;
   logic [FM_W-1:0]      rd_dat;

   glb_fm_rd_port_if mif ();

   glb_fm_rd_port dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .mif            (mif),
      .GLBSRAM_RdEn   (GLBSRAM_RdEn),
      .GLBSRAM_RdAddr (GLBSRAM_RdAddr),
      .SRAMGLB_RdDat  (rd_dat)
   );

   always #5 clk = ~clk;

   // SRAM model: one-cycle read latency.
   logic [FM_W-1:0] sram [1 << IDX_WIDTH];
   always @(posedge clk) begin
      if (GLBSRAM_RdEn) rd_dat <= sram[GLBSRAM_RdAddr];
   end

   // Reference model: per-channel queues of returned words plus one in-flight read.
   logic [FM_W-1:0]      mq [POOL_CORE][$];
   bit                   inf_vld;
   int                   inf_ch;
   logic [FM_W-1:0]      inf_dat;
   int                   rr;
   logic [IDX_WIDTH-1:0] last_addr;

   logic [POOL_CORE-1:0] s_rdy, s_fv;
   logic                 s_rden;
   logic [IDX_WIDTH-1:0] s_addr;
   logic [FM_W-1:0]      s_fm [POOL_CORE];

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [FM_W-1:0] act, input logic [FM_W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [IDX_WIDTH-1:0] req_addr(input int ch);
      return mif.MIFGLB_Addr[IDX_WIDTH*ch +: IDX_WIDTH];
   endfunction

   task automatic set_addr(input int ch, input logic [IDX_WIDTH-1:0] a);
      mif.MIFGLB_Addr[IDX_WIDTH*ch +: IDX_WIDTH] = a;
   endtask

   task automatic drive(input logic [POOL_CORE-1:0] vld, input logic [POOL_CORE-1:0] rdy);
      mif.MIFGLB_AddrVld = vld;
      mif.MIFGLB_FmRdy   = rdy;
   endtask

   // Called at a negedge with inputs applied: sample, compare with the model,
   // advance the model across the next posedge, return at the following negedge.
   task automatic tick();
      int                   g, rsv, j;
      logic [POOL_CORE-1:0] pop, e_rdy, e_fv;
      logic [IDX_WIDTH-1:0] e_addr;
      logic [FM_W-1:0]      e_fm;
      #1;
      s_rdy  = mif.GLBMIF_AddrRdy;
      s_fv   = mif.GLBMIF_FmVld;
      s_rden = GLBSRAM_RdEn;
      s_addr = GLBSRAM_RdAddr;
      for (int i = 0; i < POOL_CORE; i++) s_fm[i] = mif.GLBMIF_Fm[FM_W*i +: FM_W];
      g   = -1;
      pop = '0;
      if (!rst_n) begin
         for (int i = 0; i < POOL_CORE; i++) mq[i].delete();
         inf_vld   = 1'b0;
         rr        = 0;
         last_addr = '0;
      end else begin
         for (int i = 0; i < POOL_CORE; i++) begin
            pop[i] = (mq[i].size() > 0) && mif.MIFGLB_FmRdy[i];
         end
         for (int off = 0; off < POOL_CORE; off++) begin
            j   = (rr + off) % POOL_CORE;
            rsv = mq[j].size() + ((inf_vld && inf_ch == j) ? 1 : 0);
            if (g < 0 && mif.MIFGLB_AddrVld[j] && (rsv < FIFO_DEPTH || pop[j])) g = j;
         end
      end
      e_rdy  = '0;
      e_addr = last_addr;
      if (g >= 0) begin
         e_rdy[g] = 1'b1;
         e_addr   = req_addr(g);
      end
      chk("AddrRdy", FM_W'(s_rdy), FM_W'(e_rdy));
      chk("RdEn", FM_W'(s_rden), FM_W'(g >= 0));
      chk("RdAddr", FM_W'(s_addr), FM_W'(e_addr));
      for (int i = 0; i < POOL_CORE; i++) begin
         e_fv[i] = mq[i].size() > 0;
         e_fm    = e_fv[i] ? mq[i][0] : '0;
         chk($sformatf("Fm[%0d]", i), s_fm[i], e_fm);
      end
      chk("FmVld", FM_W'(s_fv), FM_W'(e_fv));
      if (rst_n) begin
         for (int i = 0; i < POOL_CORE; i++) if (pop[i]) void'(mq[i].pop_front());
         if (inf_vld) mq[inf_ch].push_back(inf_dat);
         inf_vld = (g >= 0);
         if (g >= 0) begin
            inf_ch    = g;
            inf_dat   = sram[e_addr];
            last_addr = e_addr;
            rr        = (g + 1) % POOL_CORE;
         end
      end
      @(negedge clk);
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1);
   end

   initial begin
      int                   ngr;
      logic [POOL_CORE-1:0] exp1;
      for (int a = 0; a < (1 << IDX_WIDTH); a++) begin
         for (int w = 0; w < FM_W / 32; w++) sram[a][32*w +: 32] = $urandom();
      end
      sram[10'h015] = {64{8'hA5}};
      rd_dat = '0;
      mif.MIFGLB_Addr = '0;
      drive('1, '1);
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      @(negedge clk);

      // Reset state with all requests asserted.
      tick();
      chk("rst_rdy", FM_W'(s_rdy), '0);
      chk("rst_rden", FM_W'(s_rden), '0);
      chk("rst_fv", FM_W'(s_fv), '0);
      tick();
      rst_n = 1'b1;
      drive('0, '1);
      tick();

      // Single request on channel 2.
      set_addr(2, 10'h015);
      drive(6'b000100, '1);
      tick();
      chk("single_rdy", FM_W'(s_rdy), FM_W'(6'b000100));
      chk("single_rden", FM_W'(s_rden), FM_W'(1'b1));
      chk("single_addr", FM_W'(s_addr), FM_W'(10'h015));
      drive('0, '1);
      tick();
      chk("single_fv_t1", FM_W'(s_fv), '0);
      tick();
      chk("single_fv_t2", FM_W'(s_fv), FM_W'(6'b000100));
      chk("single_fm", s_fm[2], {64{8'hA5}});
      tick();

      // Round-robin from a fresh pointer.
      reset_pulse();
      drive('1, '1);
      for (int n = 0; n < 12; n++) begin
         for (int c = 0; c < POOL_CORE; c++) set_addr(c, IDX_WIDTH'($urandom()));
         tick();
         exp1 = '0;
         exp1[n % POOL_CORE] = 1'b1;
         chk("rr_grant", FM_W'(s_rdy), FM_W'(exp1));
      end
      drive('0, '1);
      repeat (3) tick();

      // Back-pressure on channel 0.
      reset_pulse();
      ngr = 0;
      for (int t = 0; t < 6; t++) begin
         set_addr(0, IDX_WIDTH'(10'h100 + t));
         drive(6'b000001, 6'b111110);
         tick();
         ngr += int'(s_rdy[0]);
      end
      chk("bp_grants", FM_W'(ngr), FM_W'(2));
      chk("bp_fv", FM_W'(s_fv[0]), FM_W'(1'b1));
      chk("bp_head", s_fm[0], sram[10'h100]);
      set_addr(0, 10'h106);
      drive(6'b000001, '1);
      tick();
      chk("bp_resume", FM_W'(s_rdy), FM_W'(6'b000001));
      drive('0, '1);
      tick();
      chk("bp_next", s_fm[0], sram[10'h101]);
      repeat (4) tick();

      // Streaming on channel 3.
      for (int t = 0; t < 14; t++) begin
         if (t < 10) begin
            set_addr(3, IDX_WIDTH'(t));
            drive(6'b001000, '1);
         end else begin
            drive('0, '1);
         end
         tick();
         if (t < 10) chk("stream_rdy", FM_W'(s_rdy), FM_W'(6'b001000));
         if (t >= 2 && t < 12) begin
            chk("stream_fv", FM_W'(s_fv[3]), FM_W'(1'b1));
            chk("stream_fm", s_fm[3], sram[t-2]);
         end
      end

      // Skip an ineligible (full) channel.
      reset_pulse();
      drive(6'b000010, 6'b111101);
      tick();
      tick();
      drive(6'b000011, 6'b111101);
      tick();
      chk("skip_g0", FM_W'(s_rdy), FM_W'(6'b000001));
      drive(6'b010010, 6'b111101);
      tick();
      chk("skip_g4", FM_W'(s_rdy), FM_W'(6'b010000));
      drive(6'b010001, 6'b111101);
      tick();
      chk("skip_rr5", FM_W'(s_rdy), FM_W'(6'b000001));
      drive('0, '1);
      repeat (5) tick();

      // Reset one cycle after a grant.
      set_addr(2, IDX_WIDTH'($urandom()));
      drive(6'b000100, '1);
      tick();
      chk("rstmid_grant", FM_W'(s_rdy), FM_W'(6'b000100));
      rst_n = 1'b0;
      drive('1, '1);
      tick();
      chk("rstmid_rdy", FM_W'(s_rdy), '0);
      chk("rstmid_rden", FM_W'(s_rden), '0);
      chk("rstmid_fv", FM_W'(s_fv), '0);
      tick();
      rst_n = 1'b1;
      drive('0, '1);
      for (int t = 0; t < 3; t++) begin
         tick();
         chk("rstmid_stale", FM_W'(s_fv), '0);
      end
      drive(6'b100001, '1);
      tick();
      chk("rstmid_rr0", FM_W'(s_rdy), FM_W'(6'b000001));

      // Randomized traffic with mixed back-pressure.
      for (int t = 0; t < 600; t++) begin
         for (int c = 0; c < POOL_CORE; c++) set_addr(c, IDX_WIDTH'($urandom()));
         drive(POOL_CORE'($urandom()), POOL_CORE'($urandom() | $urandom()));
         if (t == 300) reset_pulse();
         else tick();
      end
      drive('0, '1);
      repeat (6) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
